// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the synchronous FIFO.
// Holds default WIDTH/DEPTH and the address/level width functions.
package fifo_pkg;

    localparam int DEF_WIDTH = 128;
    localparam int DEF_DEPTH = 4096;

    // Pointer width; a 1-bit pointer still works for DEPTH=2.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Level counts 0..DEPTH inclusive, hence one extra bit.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: one synchronous write, one async read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module fifo_sdp_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterized single-clock FIFO with level, status and sticky errors.
// Ports: clk, rst (async active-low), wr_en/wr_data, rd_en, clr_err,
//        rd_data/rd_valid, full/empty/almost_full/almost_empty, level,
//        overflow/underflow. PARAM_SYNC_FIFO_FWFT_EN selects FWFT read.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          rd_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = addr_width(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] ram_rdata;

    // Status is purely a function of the registered level.
    assign full         = (level == LW'(DEPTH));
    assign empty        = (level == '0);
    assign almost_full  = (level >= LW'(AF_LEVEL));
    assign almost_empty = (level <= LW'(AE_LEVEL));

    // Full rejects the write, empty rejects the read, so a simultaneous
    // request at either boundary moves the level by exactly one.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    fifo_sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // DEPTH is a power of two, so natural overflow wraps the pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= '0;
        end else if (wr_acc && !rd_acc) begin
            level <= level + LW'(1);
        end else if (rd_acc && !wr_acc) begin
            level <= level - LW'(1);
        end
    end

    // A new error event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_en && full) || (overflow && !clr_err);
            underflow <= (rd_en && empty) || (underflow && !clr_err);
        end
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    // Head word is always presented; rd_en simply pops it.
    assign rd_data  = ram_rdata;
    assign rd_valid = !empty;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= ram_rdata;
            end
        end
    end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomized and directed bench for param_sync_fifo (8x4, AF=3, AE=1).
// Compares every cycle against a queue-based reference model.
module tb_param_sync_fifo;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int AE = 1;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [W-1:0]  wr_data;
    logic          rd_en;
    logic          clr_err;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [LW-1:0] level;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] q[$];
    bit           m_ov;
    bit           m_un;
    bit           m_valid;
    logic [W-1:0] m_data;

    always #5 clk = ~clk;

    param_sync_fifo #(
        .WIDTH    (W),
        .DEPTH    (D),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, ".level"}, 32'(level), 32'(n));
        check({tag, ".full"}, 32'(full), 32'(n == D));
        check({tag, ".empty"}, 32'(empty), 32'(n == 0));
        check({tag, ".afull"}, 32'(almost_full), 32'(n >= AF));
        check({tag, ".aempty"}, 32'(almost_empty), 32'(n <= AE));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ov));
        check({tag, ".unf"}, 32'(underflow), 32'(m_un));
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        check({tag, ".rvalid"}, 32'(rd_valid), 32'(n != 0));
        if (n != 0) begin
            check({tag, ".rdata"}, 32'(rd_data), 32'(q[0]));
        end
`else
        check({tag, ".rvalid"}, 32'(rd_valid), 32'(m_valid));
        check({tag, ".rdata"}, 32'(rd_data), 32'(m_data));
`endif
    endtask

    // Reference behaviour: a bounded queue with sticky error bits.
    task automatic model(input bit w, input logic [W-1:0] wd,
                         input bit r, input bit c);
        bit is_full;
        bit is_empty;
        is_full  = (q.size() == D);
        is_empty = (q.size() == 0);
        m_ov = (w && is_full) || (m_ov && !c);
        m_un = (r && is_empty) || (m_un && !c);
        m_valid = r && !is_empty;
        if (r && !is_empty) begin
            m_data = q.pop_front();
        end
        if (w && !is_full) begin
            q.push_back(wd);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ov    = 1'b0;
        m_un    = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    task automatic step(input string tag, input bit w,
                        input logic [W-1:0] wd, input bit r,
                        input bit c);
        wr_en   = w;
        wr_data = wd;
        rd_en   = r;
        clr_err = c;
        @(posedge clk);
        model(w, wd, r, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [W-1:0] d;
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            d = W'((i + 1) * 17);
            step("fill", 1'b1, d, 1'b0, 1'b0);
        end
        step("ovf", 1'b1, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step("drain", 1'b0, '0, 1'b1, 1'b0);
        end
        step("idle", 1'b0, '0, 1'b0, 1'b0);
        step("unf", 1'b0, '0, 1'b1, 1'b0);
        step("clr", 1'b0, '0, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            d = W'((i + 1) * 17);
            step("fill2", 1'b1, d, 1'b0, 1'b0);
        end
        step("both_full", 1'b1, 8'h66, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("drain2", 1'b0, '0, 1'b1, 1'b0);
        end
        step("both_empty", 1'b1, 8'h77, 1'b1, 1'b0);
        step("drain3", 1'b0, '0, 1'b1, 1'b0);
        step("clr2", 1'b0, '0, 1'b0, 1'b1);

        step("stream", 1'b1, 8'hA0, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            d = 8'hA0 + W'(i);
            step("stream", 1'b1, d, 1'b1, 1'b0);
            check("stream.le1", 32'(level <= 1), 32'd1);
        end
        step("stream_end", 1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            step("pre_rst", 1'b1, W'($urandom), 1'b0, 1'b0);
        end
        #3;
        rst = 1'b0;
        #1;
        check("arst.level", 32'(level), 32'd0);
        check("arst.empty", 32'(empty), 32'd1);
        check("arst.full", 32'(full), 32'd0);
        check("arst.rvalid", 32'(rd_valid), 32'd0);
        model_reset();
        @(negedge clk);
        check_all("in_rst");
        rst = 1'b1;

        for (int i = 0; i < 600; i++) begin
            bit w;
            bit r;
            bit c;
            if ((i / 50) % 2 == 0) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            c = ($urandom_range(0, 15) == 0);
            step("rand", w, W'($urandom), r, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
